// File: rtl/mapper_pkg.sv
// Shared constants and types for the cartridge mapper system-register page.
package mapper_pkg;

   localparam logic [15:0] REG_PAGE   = 16'hA130;
   localparam logic [6:0]  REG_CTRL   = 7'h78;
   localparam int unsigned BANK_NUM   = 8;
   localparam int unsigned BANK_IDX_W = 3;
   localparam int unsigned OFF_W      = 7;
   localparam int unsigned BYTE_W     = 8;

   typedef logic [BANK_IDX_W-1:0] bank_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      COMMIT,
      HOLD
   } wr_state_t;

   // Offsets $A130F3..$A130FF select a writable bank slot (slot 0 is fixed).
   function automatic logic is_bank_off(input logic [OFF_W-1:0] off);
      return (off[6:3] == 4'hF) && (off[2:0] != 3'd0);
   endfunction

endpackage

// File: rtl/bus_wr_sync.sv
// Synchronises the async 68k write qualifier into clk50 (falling edge) and
// filters it through a settle FSM that emits one commit per bus write cycle.
module bus_wr_sync #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       qual,
   input  logic [6:0] adr,
   input  logic [7:0] dat,
   output logic       commit,
   output logic [6:0] cap_adr,
   output logic [7:0] cap_dat
);
   import mapper_pkg::*;

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   logic             qual_s1, qual_s2, qual_prev;
   logic [OFF_W-1:0] adr_s1, adr_s2;
   logic [BYTE_W-1:0] dat_s1, dat_s2;

   wr_state_t        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             commit_nx;
   logic [OFF_W-1:0] cap_adr_nx;
   logic [BYTE_W-1:0] cap_dat_nx;

   // Qualifier flops reset high so a strobe already active at reset release
   // is never seen as a fresh rising edge.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         qual_s1   <= 1'b1;
         qual_s2   <= 1'b1;
         qual_prev <= 1'b1;
         adr_s1    <= '0;
         adr_s2    <= '0;
         dat_s1    <= '0;
         dat_s2    <= '0;
      end else begin
         qual_s1   <= qual;
         qual_s2   <= qual_s1;
         qual_prev <= qual_s2;
         adr_s1    <= adr;
         adr_s2    <= adr_s1;
         dat_s1    <= dat;
         dat_s2    <= dat_s1;
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         commit  <= 1'b0;
         cap_adr <= '0;
         cap_dat <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         commit  <= commit_nx;
         cap_adr <= cap_adr_nx;
         cap_dat <= cap_dat_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      commit_nx  = 1'b0;
      cap_adr_nx = cap_adr;
      cap_dat_nx = cap_dat;
      case (state)
         IDLE: begin
            if (qual_s2 && !qual_prev) begin
               state_nx = SETTLE;
               cnt_nx   = '0;
            end
         end
         SETTLE: begin
            if (!qual_s2) begin
               state_nx = IDLE;
            end else if (cnt == SETTLE_LAST) begin
               state_nx   = COMMIT;
               commit_nx  = 1'b1;
               cap_adr_nx = adr_s2;
               cap_dat_nx = dat_s2;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         COMMIT: state_nx = HOLD;
         HOLD: begin
            if (!qual_s2) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: rtl/sys_reg_bank.sv
// $A130xx system-register bank: RAM enable/write-protect and SSF2-style bank
// registers. Define BANK_REG_READBACK_EN to make the page readable.
module sys_reg_bank #(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned BANK_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                as_n,
   input  logic                oe_n,
   input  logic                we_lo_n,
   input  logic [23:1]         addr,
   input  logic [15:0]         data_in,
   output logic                ram_on,
   output logic                ram_wp,
   output logic [8*BANK_W-1:0] bank,
   output logic                reg_wr,
   output logic [6:0]          reg_adr,
   output logic [7:0]          reg_dat,
   output logic                rd_oe,
   output logic [15:0]         rd_dat
);
   import mapper_pkg::*;

   logic                                 qual_c;
   logic                                 commit;
   logic [OFF_W-1:0]                     cap_adr;
   logic [BYTE_W-1:0]                    cap_dat;
   logic [BANK_NUM-1:1][BANK_W-1:0]      bank_q;

   assign qual_c = !as_n && !we_lo_n && (addr[23:8] == REG_PAGE);

   bus_wr_sync #(
      .SETTLE_CYC (SETTLE)
   ) u_wr_sync (
      .clk     (clk),
      .rst     (rst),
      .qual    (qual_c),
      .adr     (addr[7:1]),
      .dat     (data_in[7:0]),
      .commit  (commit),
      .cap_adr (cap_adr),
      .cap_dat (cap_dat)
   );

   assign reg_wr  = commit;
   assign reg_adr = cap_adr;
   assign reg_dat = cap_dat;

   // Slot 0 holds the vector area and is hard-wired to page 0.
   assign bank = {bank_q, BANK_W'(0)};

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         ram_on <= 1'b0;
         ram_wp <= 1'b0;
         for (int unsigned n = 1; n < BANK_NUM; n++) begin
            bank_q[n] <= BANK_W'(n);
         end
      end else if (commit) begin
         if (cap_adr == REG_CTRL) begin
            ram_on <= cap_dat[0];
            ram_wp <= cap_dat[1];
         end else if (is_bank_off(cap_adr)) begin
            for (int unsigned n = 1; n < BANK_NUM; n++) begin
               if (cap_adr[2:0] == bank_idx_t'(n)) bank_q[n] <= BANK_W'(cap_dat);
            end
         end
      end
   end

`ifdef BANK_REG_READBACK_EN
   logic [BANK_W-1:0] bank_sel;
   logic              unused_bits;

   assign unused_bits = ^data_in[15:8];

   // Readback drives the CPU bus combinationally while the read strobe is low.
   always_comb begin
      bank_sel = '0;
      rd_oe    = 1'b0;
      rd_dat   = '0;
      for (int unsigned n = 1; n < BANK_NUM; n++) begin
         if (addr[3:1] == bank_idx_t'(n)) bank_sel = bank_q[n];
      end
      if (rst && !as_n && !oe_n && (addr[23:8] == REG_PAGE) && (addr[7:4] == 4'hF)) begin
         rd_oe = 1'b1;
         if (addr[3:1] == bank_idx_t'(0)) rd_dat = {14'b0, ram_wp, ram_on};
         else                             rd_dat = {8'h00, 8'(bank_sel)};
      end
   end
`else
   logic unused_bits;

   assign unused_bits = ^{data_in[15:8], oe_n};
   assign rd_oe       = 1'b0;
   assign rd_dat      = '0;
`endif

endmodule
